mem_port_arbiter: RTL and testbench

- Shares the single memory port between two requesters: the CPU control unit's operand/write-back path (cpu_*) and the external loader/debug port (ext_*).
- Arbitrates with round-robin priority and runs one memory transaction per grant.
- Absorbs the fixed memory read latency and returns a single-cycle ack (with read data) to the owner.
- Sits between the control unit/datapath and the memory; the memory sees exactly one master.

---
 rtl/mem_port_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between the CPU path (cpu_*) and the loader/debug port (ext_*).
// Latency: write ack 2 cycles after the request is seen in ARB, read ack 2+MEM_LAT cycles.
// Backpressure: requesters hold req until their ack; requests are only sampled while idle (ARB).
module mem_port_arbiter #(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          ext_req,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_wdata,
  output logic          ext_ack,
  output logic [DW-1:0] ext_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int CW = 3;

  state_t        state_q, state_d;
  logic          last_owner_q;
  logic          owner_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic [CW-1:0] cnt_q;
  logic          any_req;
  logic          pick_ext;

  always_comb begin
    any_req  = cpu_req | ext_req;
    // on a tie the side that did not own the previous transaction wins
    pick_ext = ext_req & (~cpu_req | ~last_owner_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB:     if (any_req) state_d = ISSUE;
      ISSUE:   state_d = we_q ? DONE : WAIT;
      WAIT:    if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_owner_q <= 1'b1;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      cnt_q        <= '0;
    end else begin
      case (state_q)
        ARB: begin
          if (any_req) begin
            owner_q <= pick_ext;
            we_q    <= pick_ext ? ext_we    : cpu_we;
            addr_q  <= pick_ext ? ext_addr  : cpu_addr;
            wdata_q <= pick_ext ? ext_wdata : cpu_wdata;
          end
        end
        ISSUE: begin
          if (!we_q) cnt_q <= CW'(MEM_LAT - 1);
        end
        WAIT: begin
          // counter reaches zero exactly MEM_LAT cycles after the strobe
          if (cnt_q == '0) begin
            rdata_q <= mem_rdata;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        DONE: begin
          last_owner_q <= owner_q;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_en    = (state_q == ISSUE);
    mem_we    = mem_en & we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    busy      = (state_q != ARB);
    owner     = owner_q;
    cpu_ack   = (state_q == DONE) & ~owner_q;
    ext_ack   = (state_q == DONE) &  owner_q;
    cpu_rdata = cpu_ack ? rdata_q : '0;
    ext_rdata = ext_ack ? rdata_q : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then random traffic against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, ext_req, ext_we;
  logic [AW-1:0] cpu_addr, ext_addr;
  logic [DW-1:0] cpu_wdata, ext_wdata;
  logic          cpu_ack, ext_ack, mem_en, mem_we, busy, owner;
  logic [DW-1:0] cpu_rdata, ext_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_ack(ext_ack), .ext_rdata(ext_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  int pass_cnt = 0;
  int tot = 0;
  int cyc = 0;

  // memory seen by the DUT, and the contents the model expects
  logic [DW-1:0] env_mem [256];
  logic [DW-1:0] ref_mem [256];
  int            pend_due = -1;
  logic [DW-1:0] pend_dat;

  // model: one transaction at a time, timeline computed at grant
  int            next_arb = -1, busy_from = -1, en_cyc = -1, ack_cyc = -1, zero_cyc = -1;
  logic          last_own = 1'b1, m_own = 1'b0, m_we = 1'b0, granted_now = 1'b0;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;

  logic en_log [$];
  int   cpu_ack_cnt = 0, ext_ack_cnt = 0, cpu_en_cnt = 0;
  int   last_cpu_ack = -1, last_ext_ack = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tot++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
  endtask

  task automatic model_eval();
    int lat;
    granted_now = 1'b0;
    if (rst) begin
      next_arb = cyc + 1; last_own = 1'b1;
      busy_from = -1; en_cyc = -1; ack_cyc = -1; zero_cyc = cyc + 1;
    end else if (cyc == next_arb) begin
      if (cpu_req || ext_req) begin
        m_own   = (cpu_req && ext_req) ? ~last_own : ext_req;
        m_we    = m_own ? ext_we    : cpu_we;
        m_addr  = m_own ? ext_addr  : cpu_addr;
        m_wdata = m_own ? ext_wdata : cpu_wdata;
        lat = m_we ? 0 : LAT;
        busy_from = cyc + 1; en_cyc = cyc + 1;
        ack_cyc = cyc + 2 + lat; next_arb = ack_cyc + 1;
        m_rdata = ref_mem[m_addr];
        if (m_we) ref_mem[m_addr] = m_wdata;
        last_own = m_own; granted_now = 1'b1;
      end else begin
        next_arb = cyc + 1;
      end
    end
  endtask

  task automatic check_outputs();
    logic exp_busy, exp_ack;
    if (cyc == zero_cyc) begin
      chk("rst_zero_ctl", 32'({cpu_ack, ext_ack, mem_en, mem_we, busy, owner, cpu_rdata, ext_rdata}), 32'd0);
      chk("rst_zero_mem", 32'({mem_addr, mem_wdata}), 32'd0);
    end else begin
      exp_busy = (cyc >= busy_from) && (cyc <= ack_cyc);
      exp_ack  = (cyc == ack_cyc);
      chk("busy", 32'(busy), 32'(exp_busy));
      if (exp_busy) chk("owner", 32'(owner), 32'(m_own));
      chk("mem_en", 32'(mem_en), 32'(cyc == en_cyc));
      if (cyc == en_cyc) begin
        chk("mem_we", 32'(mem_we), 32'(m_we));
        chk("mem_addr", 32'(mem_addr), 32'(m_addr));
        if (m_we) chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
      end
      chk("cpu_ack", 32'(cpu_ack), 32'(exp_ack && !m_own));
      chk("ext_ack", 32'(ext_ack), 32'(exp_ack && m_own));
      if (exp_ack && !m_we)
        chk("rdata", 32'(m_own ? ext_rdata : cpu_rdata), 32'(m_rdata));
    end
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    cyc++;
    #1;
    // the winner is free to change its inputs once granted
    if (granted_now) begin
      if (m_own) begin
        ext_addr  = ext_addr ^ 8'($urandom_range(1, 255));
        ext_wdata = ext_wdata ^ 8'($urandom_range(1, 255));
      end else begin
        cpu_addr  = cpu_addr ^ 8'($urandom_range(1, 255));
        cpu_wdata = cpu_wdata ^ 8'($urandom_range(1, 255));
      end
    end
    @(negedge clk);
    check_outputs();
    if (mem_en) begin
      en_log.push_back(owner);
      if (!owner) cpu_en_cnt++;
      if (mem_we) env_mem[mem_addr] = mem_wdata;
      else begin pend_due = cyc + LAT; pend_dat = env_mem[mem_addr]; end
    end
    if (cpu_ack) begin cpu_ack_cnt++; last_cpu_ack = cyc; end
    if (ext_ack) begin ext_ack_cnt++; last_ext_ack = cyc; end
    mem_rdata = (cyc == pend_due) ? pend_dat : 8'($urandom);
  endtask

  // kind: 0=mem_en, 1=cpu_ack, 2=ext_ack, 3=idle
  task automatic run_until(input int kind, output int at);
    at = -1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if ((kind == 0 && mem_en) || (kind == 1 && cpu_ack) ||
          (kind == 2 && ext_ack) || (kind == 3 && !busy)) begin
        at = cyc;
        return;
      end
    end
    tot++;
    $error("FAIL timeout kind=%0d cyc=%0d observed=none expected=event", kind, cyc);
  endtask

  initial begin
    int t, c, a, n;
    logic exp_order [4];
    for (int i = 0; i < 256; i++) begin
      env_mem[i] = 8'($urandom);
      ref_mem[i] = env_mem[i];
    end
    rst = 1'b1; mem_rdata = '0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    ext_req = 0; ext_we = 0; ext_addr = '0; ext_wdata = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // CPU write 0x10 <- 0xA5
    cpu_we = 1; cpu_addr = 8'h10; cpu_wdata = 8'hA5; cpu_req = 1; t = cyc;
    run_until(0, c);
    chk("A_en_cyc", 32'(c), 32'(t + 1));
    chk("A_mem_we", 32'(mem_we), 32'd1);
    chk("A_mem_addr", 32'(mem_addr), 32'h10);
    chk("A_mem_wdata", 32'(mem_wdata), 32'hA5);
    run_until(1, c);
    cpu_req = 0;
    chk("A_ack_cyc", 32'(c), 32'(t + 2));
    chk("A_ext_quiet", 32'(ext_ack_cnt), 32'd0);

    // EXT read 0x22 returning 0x5C
    env_mem[8'h22] = 8'h5C; ref_mem[8'h22] = 8'h5C;
    run_until(3, c);
    ext_we = 0; ext_addr = 8'h22; ext_req = 1; t = cyc; n = en_log.size();
    run_until(2, c);
    ext_req = 0;
    chk("B_ack_cyc", 32'(c), 32'(t + 5));
    chk("B_rdata", 32'(ext_rdata), 32'h5C);
    chk("B_one_en", 32'(en_log.size()), 32'(n + 1));

    // both held: strict alternation starting with CPU
    run_until(3, c);
    en_log.delete();
    cpu_we = 1; cpu_req = 1; ext_we = 0; ext_req = 1;
    repeat (4) run_until(0, c);
    cpu_req = 0; ext_req = 0;
    exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) chk("C_order", 32'(en_log[i]), 32'(exp_order[i]));

    // CPU waits behind an EXT transaction already in flight
    run_until(3, c);
    ext_we = 0; ext_addr = 8'h40; ext_req = 1;
    run_until(0, c);
    cpu_we = 1; cpu_addr = 8'h33; cpu_wdata = 8'h44; cpu_req = 1;
    run_until(2, a);
    ext_req = 0;
    run_until(0, c);
    chk("D_cpu_en_cyc", 32'(c), 32'(a + 2));
    chk("D_owner", 32'(owner), 32'd0);
    chk("D_addr_latched", 32'(mem_addr), 32'h33);
    run_until(1, c);
    cpu_req = 0;

    // reset while a read is in WAIT
    run_until(3, c);
    ext_we = 0; ext_addr = 8'h51; ext_req = 1;
    run_until(0, c);
    tick();
    rst = 1; ext_req = 0; n = ext_ack_cnt;
    tick();
    rst = 0; cpu_we = 0; cpu_req = 1; ext_we = 0; ext_req = 1;
    run_until(0, c);
    chk("E_tie_cpu", 32'(owner), 32'd0);
    chk("E_no_ack", 32'(ext_ack_cnt), 32'(n));
    cpu_req = 0; ext_req = 0;

    // CPU drops req right after grant; a short pulse while busy is ignored
    run_until(3, c);
    cpu_we = 0; cpu_addr = 8'h12; cpu_req = 1;
    run_until(0, c);
    cpu_req = 0; n = cpu_ack_cnt;
    repeat (8) tick();
    chk("F_ack_once", 32'(cpu_ack_cnt), 32'(n + 1));
    ext_we = 0; ext_req = 1;
    run_until(0, c);
    ext_req = 0;
    tick();
    cpu_req = 1;
    tick();
    cpu_req = 0; n = cpu_en_cnt;
    repeat (10) tick();
    chk("F_pulse_ignored", 32'(cpu_en_cnt), 32'(n));

    // random traffic
    for (int i = 0; i < 400; i++) begin
      if (!cpu_req || last_cpu_ack == cyc) begin
        if (cpu_req && $urandom_range(0, 1) == 0) cpu_req = 0;
        else if (cpu_req || $urandom_range(0, 2) == 0) begin
          cpu_req = 1; cpu_we = 1'($urandom);
          cpu_addr = 8'($urandom_range(0, 15)); cpu_wdata = 8'($urandom);
        end
      end
      if (!ext_req || last_ext_ack == cyc) begin
        if (ext_req && $urandom_range(0, 1) == 0) ext_req = 0;
        else if (ext_req || $urandom_range(0, 2) == 0) begin
          ext_req = 1; ext_we = 1'($urandom);
          ext_addr = 8'($urandom_range(0, 15)); ext_wdata = 8'($urandom);
        end
      end
      tick();
    end
    cpu_req = 0; ext_req = 0;
    run_until(3, c);

    $display("%0d/%0d checks passed", pass_cnt, tot);
    $finish;
  end
endmodule
